morse_letter_display: RTL

MORSE_LETTER_DISPLAY -- requirements
Module: morse_letter_display

---
 rtl/morse_letter_display_pkg.sv | 17 +
 rtl/morse_letter_display_if.sv | 11 +
 rtl/morse_letter_display_lut.sv | 43 ++++
 rtl/morse_letter_display.sv | 72 +++++++
 4 files changed

// File: rtl/morse_letter_display_pkg.sv
// morse_pkg: letter codes, glyph table and slot geometry shared by the Morse display.
package morse_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SYM_W = 4;
  localparam int LEN_W = 3;
  typedef logic [4:0] letter_t;
  localparam letter_t L_BLANK = 5'd0;
  localparam letter_t L_ERROR = 5'd31;
  // active-high segment patterns {g,f,e,d,c,b,a}, index 0 = A ... 25 = Z
  localparam logic [25:0][6:0] GLYPH_ON = {
    7'h5B, 7'h6E, 7'h49, 7'h2A, 7'h1C, 7'h3E, 7'h78, 7'h6D, 7'h50, 7'h67, 7'h73, 7'h3F, 7'h54,
    7'h37, 7'h38, 7'h75, 7'h1E, 7'h30, 7'h76, 7'h3D, 7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77
  };
  function automatic logic [6:0] glyph(letter_t c);
    return c == L_BLANK ? 7'h7F : c > 5'd26 ? 7'h3F : ~GLYPH_ON[c - 5'd1];
  endfunction
endpackage

// File: rtl/morse_letter_display_if.sv
// morse_letter_display_if: symbol inputs and multiplexed 7-segment outputs of the Morse display.
interface morse_letter_display_if;
  import morse_pkg::*;
  logic [NUM_SLOTS*SYM_W-1:0] fsm_in;
  logic [NUM_SLOTS*LEN_W-1:0] bits;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;
  modport master(output fsm_in, bits, input an, seg, dp);
  modport slave(input fsm_in, bits, output an, seg, dp);
endinterface

// File: rtl/morse_letter_display_lut.sv
// morse_lut: maps a Morse pattern (bit 0 = first symbol, 1 = dash) and length to a letter code.
module morse_lut
  import morse_pkg::*;
(
  input  logic [SYM_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output letter_t          code
);
  logic [SYM_W-1:0] p;
  always_comb begin
    p = pattern & SYM_W'((1 << len) - 1);
    case ({len, p})
      7'h00: code = L_BLANK;
      7'h10: code = 5'd5;
      7'h11: code = 5'd20;
      7'h20: code = 5'd9;
      7'h21: code = 5'd14;
      7'h22: code = 5'd1;
      7'h23: code = 5'd13;
      7'h30: code = 5'd19;
      7'h31: code = 5'd4;
      7'h32: code = 5'd18;
      7'h33: code = 5'd7;
      7'h34: code = 5'd21;
      7'h35: code = 5'd11;
      7'h36: code = 5'd23;
      7'h37: code = 5'd15;
      7'h40: code = 5'd8;
      7'h41: code = 5'd2;
      7'h42: code = 5'd12;
      7'h43: code = 5'd26;
      7'h44: code = 5'd6;
      7'h45: code = 5'd3;
      7'h46: code = 5'd16;
      7'h48: code = 5'd22;
      7'h49: code = 5'd24;
      7'h4B: code = 5'd17;
      7'h4D: code = 5'd25;
      7'h4E: code = 5'd10;
      default: code = L_ERROR;
    endcase
  end
endmodule

// File: rtl/morse_letter_display.sv
// morse_letter_display: scans eight snapshotted Morse slots onto a multiplexed 7-segment display.
// Define MORSE_DP_CURSOR_EN to light dp on the lowest-numbered empty slot.
module morse_letter_display
  import morse_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic clock,
  input logic reset,
  morse_letter_display_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] pre;
  logic [2:0] digit;
  logic started;
  logic tick;
  logic frame_start;
  logic [NUM_SLOTS*SYM_W-1:0] snap_p;
  logic [NUM_SLOTS*LEN_W-1:0] snap_l;
  letter_t cur_code;
  logic cur_hit;
  logic s1_valid;
  logic [2:0] s1_digit;
  letter_t s1_code;
  logic s1_cur;
  assign tick = pre == PW'(REFRESH_DIV - 1);
  assign frame_start = ~started | (tick & (digit == 3'd7));
  morse_lut u_lut (
    .pattern(snap_p[SYM_W*digit +: SYM_W]),
    .len    (snap_l[LEN_W*digit +: LEN_W]),
    .code   (cur_code)
  );
`ifdef MORSE_DP_CURSOR_EN
  // scanning high to low leaves the decision of the lowest empty slot in place
  always_comb begin
    cur_hit = 1'b0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--)
      if (snap_l[LEN_W*k +: LEN_W] == '0) cur_hit = 3'(k) == digit;
  end
`else
  assign cur_hit = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
      digit <= '0;
      started <= 1'b0;
      snap_p <= '0;
      snap_l <= '0;
      s1_valid <= 1'b0;
      s1_digit <= '0;
      s1_code <= L_BLANK;
      s1_cur <= 1'b0;
      bus.an <= 8'hFF;
      bus.seg <= 7'h7F;
      bus.dp <= 1'b1;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      digit <= digit + 3'(tick);
      started <= 1'b1;
      snap_p <= frame_start ? bus.fsm_in : snap_p;
      snap_l <= frame_start ? bus.bits : snap_l;
      s1_valid <= 1'b1;
      s1_digit <= digit;
      s1_code <= cur_code;
      s1_cur <= cur_hit;
      bus.an <= s1_valid ? ~(8'h80 >> s1_digit) : 8'hFF;
      bus.seg <= glyph(s1_code);
      bus.dp <= ~s1_cur;
    end
  end
endmodule
